// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array job sequencer.
package systolic_pkg;

    // Pass-through latency of one PE hop (a_in->a_out, b_in->b_out)
    localparam int HOP_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    // Cycles from the start sample to the done pulse for an n x n array and inner dimension k
    function automatic int job_latency(input int n, input int k);
        if (k == 0)
            return 2;
        return 2 + k + HOP_LAT * (n - 1) + HOP_LAT * n;
    endfunction

endpackage

// File: rtl/skew_lane_gen.sv
// One skewed read lane: enabled while 0 <= t - offset < k, address = t - offset.
// The offset is compared before subtracting so the relative index never wraps.
module skew_lane_gen #(
    parameter int TW = 5,
    parameter int KW = 4
) (
    input  logic          active,
    input  logic [TW-1:0] t,
    input  logic [TW-1:0] offset,
    input  logic [KW:0]   k,
    output logic          en,
    output logic [KW-1:0] addr
);

    localparam int CW = (TW > KW + 1) ? TW : KW + 1;

    logic [CW-1:0] rel;

    // Lane enable and address from the feed counter; inactive lanes present address 0
    always_comb begin
        en   = 1'b0;
        addr = '0;
        rel  = CW'(t) - CW'(offset);
        if (active && (t >= offset)) begin
            if (rel < CW'(k)) begin
                en   = 1'b1;
                addr = rel[KW-1:0];
            end
        end
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an N x N systolic MAC array: clears the array, feeds skewed
// operand reads to the row A buffers and column B buffers, drains, and pulses done.
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = 4,
    parameter int K_MAX = 16,
    parameter int KW    = (K_MAX > 1) ? $clog2(K_MAX) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW:0]     cfg_k,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            cfg_err,
    output logic            arr_rst_n,
    output logic [N-1:0]    a_rd_en,
    output logic [N*KW-1:0] a_rd_addr,
    output logic [N-1:0]    b_rd_en,
    output logic [N*KW-1:0] b_rd_addr,
    output logic [N-1:0]    row_valid,
    output logic [N-1:0]    col_valid
);

    localparam int TW = $clog2(K_MAX + HOP_LAT * (N - 1) + 1);
    localparam int DW = $clog2(HOP_LAT * N + 1);

    localparam logic [KW:0]   K_MAX_V    = (KW + 1)'(K_MAX);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(HOP_LAT * N - 1);

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            reject;
    logic            feeding;
    logic [KW:0]     k_q;
    logic [TW-1:0]   t_q;
    logic [TW-1:0]   feed_last;
    logic [DW-1:0]   drain_q;

    assign feeding   = (state_q == FEED);
    assign feed_last = TW'(k_q) + TW'(HOP_LAT * (N - 1)) - TW'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic and status outputs; abort outranks every transition out of a busy state
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_k <= K_MAX_V) begin
                        state_d = CLEAR;
                        accept  = 1'b1;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                busy    = 1'b1;
                state_d = (k_q == '0) ? DONE : FEED;
            end
            FEED: begin
                busy = 1'b1;
                if (t_q == feed_last)
                    state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == DRAIN_LAST)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE))
            state_d = IDLE;
    end

    // Job configuration, feed and drain counters; counters restart whenever their state is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            t_q     <= '0;
            drain_q <= '0;
        end else begin
            if (accept)
                k_q <= cfg_k;
            t_q     <= (feeding && (state_d == FEED)) ? t_q + TW'(1) : '0;
            drain_q <= ((state_q == DRAIN) && (state_d == DRAIN)) ? drain_q + DW'(1) : '0;
        end
    end

    // Registered array clear (low exactly during CLEAR) and reject pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_rst_n <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            arr_rst_n <= (state_d != CLEAR);
            cfg_err   <= reject;
        end
    end

    // Edge valids follow the read enables by the one-cycle buffer read latency; abort kills them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid <= '0;
            col_valid <= '0;
        end else if (abort) begin
            row_valid <= '0;
            col_valid <= '0;
        end else begin
            row_valid <= a_rd_en;
            col_valid <= b_rd_en;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane_gen #(
            .TW (TW),
            .KW (KW)
        ) u_a_lane (
            .active (feeding),
            .t      (t_q),
            .offset (TW'(HOP_LAT * i)),
            .k      (k_q),
            .en     (a_rd_en[i]),
            .addr   (a_rd_addr[i*KW +: KW])
        );

        skew_lane_gen #(
            .TW (TW),
            .KW (KW)
        ) u_b_lane (
            .active (feeding),
            .t      (t_q),
            .offset (TW'(HOP_LAT * i)),
            .k      (k_q),
            .en     (b_rd_en[i]),
            .addr   (b_rd_addr[i*KW +: KW])
        );
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: drives jobs, models the operand buffers and a
// behavioural PE grid fed by the DUT's reads/valids, and compares against A*B.
module tb_systolic_array_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int KW    = 4;
    localparam int HOP   = 2;
    localparam int MAXC  = 48;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [KW:0]     cfg_k;
    logic            abort;
    logic            busy;
    logic            done;
    logic            cfg_err;
    logic            arr_rst_n;
    logic [N-1:0]    a_rd_en;
    logic [N*KW-1:0] a_rd_addr;
    logic [N-1:0]    b_rd_en;
    logic [N*KW-1:0] b_rd_addr;
    logic [N-1:0]    row_valid;
    logic [N-1:0]    col_valid;

    int n_cmp;
    int n_fail;

    systolic_array_ctrl #(
        .N     (N),
        .K_MAX (K_MAX),
        .KW    (KW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_k     (cfg_k),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .arr_rst_n (arr_rst_n),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .row_valid (row_valid),
        .col_valid (col_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffers: row i of A at A_mem[i][k], column j of B at B_mem[j][k] = B[k][j]
    logic [7:0]  A_mem [N][K_MAX];
    logic [7:0]  B_mem [N][K_MAX];
    logic [31:0] gold  [N][N];

    // Per-cycle record of the DUT outputs, cycle 1 = first cycle after the start sample
    logic            r_busy [MAXC];
    logic            r_done [MAXC];
    logic            r_err  [MAXC];
    logic            r_arr  [MAXC];
    logic [N-1:0]    r_a_en [MAXC];
    logic [N-1:0]    r_b_en [MAXC];
    logic [N*KW-1:0] r_a_ad [MAXC];
    logic [N*KW-1:0] r_b_ad [MAXC];
    logic [N-1:0]    r_rv   [MAXC];
    logic [N-1:0]    r_cv   [MAXC];

    // Behavioural PE grid: operands hop east/south with a 2-cycle delay, accumulate on valid
    logic [N-1:0]    m_a_en, m_b_en, m_rv;
    logic [N*KW-1:0] m_a_ad, m_b_ad;
    logic            m_arr;
    logic [7:0]      a_rdata [N];
    logic [7:0]      b_rdata [N];
    logic [7:0]      a_p0 [N][N];
    logic [7:0]      a_p1 [N][N];
    logic [7:0]      b_p0 [N][N];
    logic [7:0]      b_p1 [N][N];
    logic            v_p0 [N][N];
    logic            v_p1 [N][N];
    logic [31:0]     c_mod [N][N];

    function automatic logic [7:0] pa(int i, int j);
        return (j == 0) ? a_rdata[i] : a_p1[i][j-1];
    endfunction

    function automatic logic [7:0] pb(int i, int j);
        return (i == 0) ? b_rdata[j] : b_p1[i-1][j];
    endfunction

    function automatic logic pv(int i, int j);
        return (j == 0) ? m_rv[i] : v_p1[i][j-1];
    endfunction

    // Capture DUT outputs mid-cycle so the model sees stable values at the next edge
    always @(negedge clk) begin
        m_a_en <= a_rd_en;
        m_b_en <= b_rd_en;
        m_a_ad <= a_rd_addr;
        m_b_ad <= b_rd_addr;
        m_rv   <= row_valid;
        m_arr  <= arr_rst_n;
    end

    // PE grid and buffer read model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                a_rdata[i] <= '0;
                b_rdata[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    a_p0[i][j] <= '0; a_p1[i][j] <= '0;
                    b_p0[i][j] <= '0; b_p1[i][j] <= '0;
                    v_p0[i][j] <= 1'b0; v_p1[i][j] <= 1'b0;
                    c_mod[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_rdata[i] <= m_a_en[i] ? A_mem[i][m_a_ad[i*KW +: KW]] : 8'd0;
                b_rdata[i] <= m_b_en[i] ? B_mem[i][m_b_ad[i*KW +: KW]] : 8'd0;
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (!m_arr) begin
                        a_p0[i][j] <= '0; a_p1[i][j] <= '0;
                        b_p0[i][j] <= '0; b_p1[i][j] <= '0;
                        v_p0[i][j] <= 1'b0; v_p1[i][j] <= 1'b0;
                        c_mod[i][j] <= '0;
                    end else begin
                        a_p0[i][j] <= pa(i, j); a_p1[i][j] <= a_p0[i][j];
                        b_p0[i][j] <= pb(i, j); b_p1[i][j] <= b_p0[i][j];
                        v_p0[i][j] <= pv(i, j); v_p1[i][j] <= v_p0[i][j];
                        if (pv(i, j))
                            c_mod[i][j] <= c_mod[i][j] + 32'(pa(i, j)) * 32'(pb(i, j));
                    end
                end
            end
        end
    end

    function automatic int exp_done(int k);
        return (k == 0) ? 2 : 2 + k + HOP * (N - 1) + HOP * N;
    endfunction

    // Lane i is reading operand (c - 2 - 2i) in cycle c of an unaborted job
    function automatic bit lane_on(int c, int i, int k);
        int t;
        t = c - 2;
        return (c >= 2) && (t - HOP * i >= 0) && (t - HOP * i < k);
    endfunction

    task automatic load_data(input bit ident);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K_MAX; k++) begin
                A_mem[i][k] = ident ? ((i == k) ? 8'd1 : 8'd0) : 8'($urandom);
                B_mem[i][k] = 8'($urandom);
            end
    endtask

    task automatic compute_gold(input int kk);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                gold[i][j] = 0;
                for (int k = 0; k < kk; k++)
                    gold[i][j] = gold[i][j] + 32'(A_mem[i][k]) * 32'(B_mem[j][k]);
            end
    endtask

    // Starts a job (caller is at a negedge), optionally aborts or re-pulses start, records ncyc cycles
    task automatic run_job(input int k0, input int ab_cyc, input int s2_cyc, input int k2, input int ncyc);
        start = 1'b1;
        cfg_k = (KW + 1)'(k0);
        abort = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            r_busy[c] = busy;    r_done[c] = done;
            r_err[c]  = cfg_err; r_arr[c]  = arr_rst_n;
            r_a_en[c] = a_rd_en; r_b_en[c] = b_rd_en;
            r_a_ad[c] = a_rd_addr; r_b_ad[c] = b_rd_addr;
            r_rv[c]   = row_valid; r_cv[c] = col_valid;
            start = (c == s2_cyc);
            if (c == s2_cyc)
                cfg_k = (KW + 1)'(k2);
            abort = (c == ab_cyc);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, cfg_err, arr_rst_n} !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got %b expected 0001", {busy, done, cfg_err, arr_rst_n});
        end
        n_cmp++;
        if ({a_rd_en, b_rd_en, row_valid, col_valid} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_enables: got %h expected 0", {a_rd_en, b_rd_en, row_valid, col_valid});
        end
        n_cmp++;
        if ({a_rd_addr, b_rd_addr} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_addr: got %h expected 0", {a_rd_addr, b_rd_addr});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic;
        int d, nd, fd, nlow, ea;
        bit on;
        load_data(1'b1);
        compute_gold(4);
        d = exp_done(4);
        run_job(4, -1, -1, 0, d + 1);
        nd = 0; fd = 0; nlow = 0;
        for (int c = 1; c <= d + 1; c++) begin
            if (r_done[c]) begin nd++; if (fd == 0) fd = c; end
            if (!r_arr[c]) nlow++;
        end
        n_cmp++;
        if (fd !== d || nd !== 1) begin
            n_fail++;
            $display("[TB] FAIL basic_done: got cycle %0d count %0d expected cycle %0d count 1", fd, nd, d);
        end
        n_cmp++;
        if (r_arr[1] !== 1'b0 || nlow !== 1) begin
            n_fail++;
            $display("[TB] FAIL basic_clear: got arr_rst_n@1=%b low cycles %0d expected 0 and 1", r_arr[1], nlow);
        end
        for (int c = 1; c <= d + 1; c++) begin
            n_cmp++;
            if (r_busy[c] !== 1'(c < d)) begin
                n_fail++;
                $display("[TB] FAIL basic_busy: cycle %0d got %b expected %b", c, r_busy[c], 1'(c < d));
            end
            for (int i = 0; i < N; i++) begin
                on = lane_on(c, i, 4);
                ea = on ? (c - 2 - HOP * i) : 0;
                n_cmp++;
                if (r_a_en[c][i] !== on || r_b_en[c][i] !== on) begin
                    n_fail++;
                    $display("[TB] FAIL basic_en: cycle %0d lane %0d got a=%b b=%b expected %b", c, i, r_a_en[c][i], r_b_en[c][i], on);
                end
                n_cmp++;
                if (int'(r_a_ad[c][i*KW +: KW]) !== ea || int'(r_b_ad[c][i*KW +: KW]) !== ea) begin
                    n_fail++;
                    $display("[TB] FAIL basic_addr: cycle %0d lane %0d got a=%0d b=%0d expected %0d", c, i, r_a_ad[c][i*KW +: KW], r_b_ad[c][i*KW +: KW], ea);
                end
                on = (c >= 2) && lane_on(c - 1, i, 4);
                n_cmp++;
                if (r_rv[c][i] !== on || r_cv[c][i] !== on) begin
                    n_fail++;
                    $display("[TB] FAIL basic_valid: cycle %0d lane %0d got row=%b col=%b expected %b", c, i, r_rv[c][i], r_cv[c][i], on);
                end
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (c_mod[i][j] !== gold[i][j]) begin
                    n_fail++;
                    $display("[TB] FAIL basic_result: c[%0d][%0d] got %0d expected %0d", i, j, c_mod[i][j], gold[i][j]);
                end
            end
    endtask

    task automatic test_k_zero;
        int fd, nd, nen;
        run_job(0, -1, -1, 0, 6);
        fd = 0; nd = 0; nen = 0;
        for (int c = 1; c <= 6; c++) begin
            if (r_done[c]) begin nd++; if (fd == 0) fd = c; end
            if (r_a_en[c] != '0 || r_b_en[c] != '0 || r_rv[c] != '0 || r_cv[c] != '0) nen++;
        end
        n_cmp++;
        if (fd !== 2 || nd !== 1) begin
            n_fail++;
            $display("[TB] FAIL kzero_done: got cycle %0d count %0d expected cycle 2 count 1", fd, nd);
        end
        n_cmp++;
        if (r_arr[1] !== 1'b0 || r_busy[1] !== 1'b1 || r_busy[2] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL kzero_clear: got arr=%b busy1=%b busy2=%b expected 0 1 0", r_arr[1], r_busy[1], r_busy[2]);
        end
        n_cmp++;
        if (nen !== 0) begin
            n_fail++;
            $display("[TB] FAIL kzero_enables: got %0d active cycles expected 0", nen);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (c_mod[i][j] !== 32'd0) begin
                    n_fail++;
                    $display("[TB] FAIL kzero_result: c[%0d][%0d] got %0d expected 0", i, j, c_mod[i][j]);
                end
            end
    endtask

    task automatic test_cfg_err;
        int ne, nb, nen;
        run_job(K_MAX + 1, -1, -1, 0, 6);
        ne = 0; nb = 0; nen = 0;
        for (int c = 1; c <= 6; c++) begin
            if (r_err[c]) ne++;
            if (r_busy[c] || r_done[c] || !r_arr[c]) nb++;
            if (r_a_en[c] != '0 || r_b_en[c] != '0) nen++;
        end
        n_cmp++;
        if (r_err[1] !== 1'b1 || ne !== 1) begin
            n_fail++;
            $display("[TB] FAIL cfgerr_pulse: got err@1=%b count %0d expected 1 and 1", r_err[1], ne);
        end
        n_cmp++;
        if (nb !== 0) begin
            n_fail++;
            $display("[TB] FAIL cfgerr_idle: got %0d busy/done/clear cycles expected 0", nb);
        end
        n_cmp++;
        if (nen !== 0) begin
            n_fail++;
            $display("[TB] FAIL cfgerr_enables: got %0d active cycles expected 0", nen);
        end
    endtask

    task automatic test_abort;
        int bad, nd, d;
        load_data(1'b0);
        run_job(4, 5, -1, 0, 30);
        n_cmp++;
        if (r_busy[5] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abort_prebusy: got %b expected 1", r_busy[5]);
        end
        bad = 0; nd = 0;
        for (int c = 1; c <= 30; c++) begin
            if (r_done[c]) nd++;
            if (c >= 6 && (r_busy[c] || r_a_en[c] != '0 || r_b_en[c] != '0 || r_rv[c] != '0 || r_cv[c] != '0)) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL abort_quiet: got %0d active cycles after abort expected 0", bad);
        end
        n_cmp++;
        if (nd !== 0) begin
            n_fail++;
            $display("[TB] FAIL abort_nodone: got %0d done pulses expected 0", nd);
        end
        load_data(1'b0);
        compute_gold(2);
        d = exp_done(2);
        run_job(2, -1, -1, 0, d + 1);
        n_cmp++;
        if (r_done[d] !== 1'b1 || r_done[d - 1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_rerun_done: got done@%0d=%b done@%0d=%b expected 1 0", d, r_done[d], d - 1, r_done[d - 1]);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (c_mod[i][j] !== gold[i][j]) begin
                    n_fail++;
                    $display("[TB] FAIL abort_rerun_result: c[%0d][%0d] got %0d expected %0d", i, j, c_mod[i][j], gold[i][j]);
                end
            end
    endtask

    task automatic test_start_while_busy;
        int d, fd, nd;
        load_data(1'b0);
        compute_gold(3);
        d = exp_done(3);
        run_job(3, -1, 5, 9, 40);
        fd = 0; nd = 0;
        for (int c = 1; c <= 40; c++)
            if (r_done[c]) begin nd++; if (fd == 0) fd = c; end
        n_cmp++;
        if (fd !== d || nd !== 1) begin
            n_fail++;
            $display("[TB] FAIL busystart_done: got cycle %0d count %0d expected cycle %0d count 1", fd, nd, d);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (c_mod[i][j] !== gold[i][j]) begin
                    n_fail++;
                    $display("[TB] FAIL busystart_result: c[%0d][%0d] got %0d expected %0d", i, j, c_mod[i][j], gold[i][j]);
                end
            end
    endtask

    task automatic test_back_to_back;
        int d;
        d = exp_done(K_MAX);
        for (int job = 0; job < 2; job++) begin
            load_data(1'b0);
            compute_gold(K_MAX);
            run_job(K_MAX, -1, -1, 0, d + 1);
            n_cmp++;
            if (r_done[d] !== 1'b1 || r_busy[d - 1] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL b2b_done: job %0d got done=%b busy_before=%b expected 1 1", job, r_done[d], r_busy[d - 1]);
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    n_cmp++;
                    if (c_mod[i][j] !== gold[i][j]) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_result: job %0d c[%0d][%0d] got %0d expected %0d", job, i, j, c_mod[i][j], gold[i][j]);
                    end
                end
        end
    endtask

    task automatic test_random_jobs;
        int k, d, fd, nen;
        for (int job = 0; job < 4; job++) begin
            k = int'($urandom_range(K_MAX, 1));
            load_data(1'b0);
            compute_gold(k);
            d = exp_done(k);
            run_job(k, -1, -1, 0, d + 1);
            fd = 0; nen = 0;
            for (int c = 1; c <= d + 1; c++) begin
                if (r_done[c] && fd == 0) fd = c;
                nen += $countones(r_a_en[c]);
            end
            n_cmp++;
            if (fd !== d) begin
                n_fail++;
                $display("[TB] FAIL rand_done: K=%0d got cycle %0d expected %0d", k, fd, d);
            end
            n_cmp++;
            if (nen !== N * k) begin
                n_fail++;
                $display("[TB] FAIL rand_reads: K=%0d got %0d reads expected %0d", k, nen, N * k);
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    n_cmp++;
                    if (c_mod[i][j] !== gold[i][j]) begin
                        n_fail++;
                        $display("[TB] FAIL rand_result: K=%0d c[%0d][%0d] got %0d expected %0d", k, i, j, c_mod[i][j], gold[i][j]);
                    end
                end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        cfg_k  = '0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K_MAX; k++) begin
                A_mem[i][k] = '0;
                B_mem[i][k] = '0;
            end
        repeat (2) @(posedge clk);
        $display("[TB] starting");
        test_reset;
        test_basic;
        test_k_zero;
        test_cfg_err;
        test_abort;
        test_start_while_busy;
        test_back_to_back;
        test_random_jobs;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
